// File: rtl/filter_capture.sv
// Captures filter output samples into a first-word fall-through FIFO and
// watches for samples that fail to follow their start strobe in time.
module filter_capture #(
  parameter int BITWIDTH    = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                          CLK,
  input  logic                          nRST,
  input  logic                          EN,
  input  logic                          START_FLAG,
  input  logic [BITWIDTH-1:0]           DATA_IN,
  input  logic                          DATA_VALID,
  input  logic                          RD_EN,
  input  logic                          CLR,
  output logic [BITWIDTH-1:0]           DATA_OUT,
  output logic                          DATA_OUT_VALID,
  output logic [$clog2(FIFO_DEPTH):0]   FILL_LEVEL,
  output logic                          OVERFLOW,
  output logic                          TIMEOUT
);

  // state | meaning
  // IDLE  | no sample outstanding
  // WAIT  | start strobe seen, counting until DATA_VALID or timeout
  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                dv_q, sf_q;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                ovf_q, ovf_d, tmo_q, tmo_d;
  logic [BITWIDTH-1:0] mem_q [FIFO_DEPTH];

  logic dv_rise, sf_rise;
  logic empty, full;
  logic wr_req, pop, push, drop, tmo_hit;

  assign dv_rise = DATA_VALID & ~dv_q;
  assign sf_rise = START_FLAG & ~sf_q;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign wr_req = EN & dv_rise;
  assign pop    = RD_EN & ~empty;
  assign push   = wr_req & (~full | pop);
  assign drop   = wr_req & full & ~pop;

  assign wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_hit = 1'b0;
    if (!EN) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sf_rise) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
        ST_WAIT: begin
          // A sample arriving on the last count still counts as on time.
          if (sf_rise) begin
            cnt_d = '0;
          end else if (dv_rise) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            tmo_hit = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign ovf_d = drop | (ovf_q & ~CLR);
  assign tmo_d = tmo_hit | (tmo_q & ~CLR);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      dv_q     <= 1'b0;
      sf_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dv_q     <= DATA_VALID;
      sf_q     <= START_FLAG;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      tmo_q    <= tmo_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= DATA_IN;
    end
  end

  assign DATA_OUT       = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign DATA_OUT_VALID = ~empty;
  assign FILL_LEVEL     = wr_ptr_q - rd_ptr_q;
  assign OVERFLOW       = ovf_q;
  assign TIMEOUT        = tmo_q;

endmodule

// File: tb/tb_filter_capture.sv
// Bench for filter_capture: fixed vector table, directed corner sequences and
// randomized traffic checked against a queue/deadline reference model.
module tb_filter_capture;
  localparam int BW = 16;
  localparam int D  = 8;
  localparam int TC = 64;

  logic          CLK = 1'b0;
  logic          nRST, EN, START_FLAG, DATA_VALID, RD_EN, CLR;
  logic [BW-1:0] DATA_IN, DATA_OUT;
  logic          DATA_OUT_VALID, OVERFLOW, TIMEOUT;
  logic [3:0]    FILL_LEVEL;

  int vectors = 0;
  int miscompares = 0;

  filter_capture #(.BITWIDTH(BW), .FIFO_DEPTH(D), .TIMEOUT_CYC(TC)) dut (
    .CLK(CLK), .nRST(nRST), .EN(EN), .START_FLAG(START_FLAG),
    .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID), .RD_EN(RD_EN), .CLR(CLR),
    .DATA_OUT(DATA_OUT), .DATA_OUT_VALID(DATA_OUT_VALID),
    .FILL_LEVEL(FILL_LEVEL), .OVERFLOW(OVERFLOW), .TIMEOUT(TIMEOUT)
  );

  always #5 CLK = ~CLK;

  // Reference model: sample queue, sticky flags, and an armed deadline.
  logic [BW-1:0] mq[$];
  bit m_ovf, m_tmo, m_prev_dv, m_prev_sf, m_armed;
  int edge_no = 0;
  int m_start = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_tmo = 0; m_prev_dv = 0; m_prev_sf = 0; m_armed = 0;
  endtask

  task automatic model_step();
    bit dvr, sfr, pop, push, ovf_set, tmo_set;
    dvr = DATA_VALID && !m_prev_dv;
    sfr = START_FLAG && !m_prev_sf;
    pop = RD_EN && (mq.size() > 0);
    push = EN && dvr;
    ovf_set = 0;
    tmo_set = 0;
    if (push && mq.size() == D && !pop) ovf_set = 1;
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(DATA_IN);
    end
    if (!EN) m_armed = 0;
    else if (sfr) begin
      m_armed = 1;
      m_start = edge_no;
    end else if (m_armed && dvr) m_armed = 0;
    else if (m_armed && (edge_no - m_start) == TC) begin
      m_armed = 0;
      tmo_set = 1;
    end
    m_ovf = ovf_set || (m_ovf && !CLR);
    m_tmo = tmo_set || (m_tmo && !CLR);
    m_prev_dv = DATA_VALID;
    m_prev_sf = START_FLAG;
  endtask

  task automatic compare_model();
    logic [BW-1:0] exp_d;
    exp_d = '0;
    if (mq.size() > 0) exp_d = mq[0];
    check("model.data_out", DATA_OUT, exp_d);
    check("model.data_out_valid", DATA_OUT_VALID, (mq.size() > 0));
    check("model.fill_level", FILL_LEVEL, mq.size());
    check("model.overflow", OVERFLOW, m_ovf);
    check("model.timeout", TIMEOUT, m_tmo);
  endtask

  task automatic cycle();
    @(posedge CLK);
    edge_no++;
    if (nRST) model_step();
    else model_reset();
    #1;
    compare_model();
  endtask

  task automatic pulse(input logic [BW-1:0] d);
    DATA_VALID = 1; DATA_IN = d;
    cycle();
    DATA_VALID = 0;
    cycle();
  endtask

  task automatic pop1();
    RD_EN = 1;
    cycle();
    RD_EN = 0;
  endtask

  task automatic sf_pulse();
    START_FLAG = 1;
    cycle();
    START_FLAG = 0;
  endtask

  task automatic clr1();
    CLR = 1;
    cycle();
    CLR = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".data_out"}, DATA_OUT, 0);
    check({tag, ".data_out_valid"}, DATA_OUT_VALID, 0);
    check({tag, ".fill_level"}, FILL_LEVEL, 0);
    check({tag, ".overflow"}, OVERFLOW, 0);
    check({tag, ".timeout"}, TIMEOUT, 0);
  endtask

  typedef struct {
    bit            en, dv, rd;
    logic [BW-1:0] din;
    logic [3:0]    fill;
    logic [BW-1:0] dout;
    bit            dov;
  } vec_t;

  vec_t tbl[12];

  initial begin
    nRST = 0; EN = 0; START_FLAG = 0; DATA_VALID = 0; RD_EN = 0; CLR = 0; DATA_IN = '0;
    model_reset();

    tbl[0]  = '{en:1, dv:1, rd:0, din:16'h8000, fill:1, dout:16'h8000, dov:1};
    tbl[1]  = '{en:1, dv:0, rd:1, din:16'h0000, fill:0, dout:16'h0000, dov:0};
    tbl[2]  = '{en:1, dv:0, rd:1, din:16'h0000, fill:0, dout:16'h0000, dov:0};
    tbl[3]  = '{en:0, dv:1, rd:0, din:16'h1111, fill:0, dout:16'h0000, dov:0};
    tbl[4]  = '{en:0, dv:1, rd:0, din:16'h1112, fill:0, dout:16'h0000, dov:0};
    tbl[5]  = '{en:1, dv:1, rd:0, din:16'h2222, fill:0, dout:16'h0000, dov:0};
    tbl[6]  = '{en:1, dv:0, rd:0, din:16'h0000, fill:0, dout:16'h0000, dov:0};
    tbl[7]  = '{en:1, dv:1, rd:0, din:16'h3333, fill:1, dout:16'h3333, dov:1};
    tbl[8]  = '{en:1, dv:1, rd:1, din:16'h4444, fill:0, dout:16'h0000, dov:0};
    tbl[9]  = '{en:1, dv:0, rd:0, din:16'h0000, fill:0, dout:16'h0000, dov:0};
    tbl[10] = '{en:1, dv:1, rd:1, din:16'h5555, fill:1, dout:16'h5555, dov:1};
    tbl[11] = '{en:1, dv:0, rd:1, din:16'h0000, fill:0, dout:16'h0000, dov:0};

    #1;
    check_all_zero("reset");
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      EN = tbl[i].en; DATA_VALID = tbl[i].dv; RD_EN = tbl[i].rd; DATA_IN = tbl[i].din;
      cycle();
      check($sformatf("tbl[%0d].fill", i), FILL_LEVEL, tbl[i].fill);
      check($sformatf("tbl[%0d].dout", i), DATA_OUT, tbl[i].dout);
      check($sformatf("tbl[%0d].dov", i), DATA_OUT_VALID, tbl[i].dov);
    end
    EN = 1; DATA_VALID = 0; RD_EN = 0; DATA_IN = '0;
    cycle();

    // Overflow: nine writes into eight slots, then drain in order.
    for (int v = 1; v <= 9; v++) pulse(16'(v));
    check("ovf.fill", FILL_LEVEL, 8);
    check("ovf.flag", OVERFLOW, 1);
    for (int v = 1; v <= 8; v++) begin
      check($sformatf("ovf.pop%0d", v), DATA_OUT, v);
      pop1();
    end
    check("ovf.drained_fill", FILL_LEVEL, 0);
    check("ovf.drained_dout", DATA_OUT, 0);
    check("ovf.sticky", OVERFLOW, 1);
    clr1();
    check("ovf.clr", OVERFLOW, 0);

    // Overflow set in the same cycle as CLR wins.
    for (int v = 1; v <= 8; v++) pulse(16'(8'h20 + v));
    DATA_VALID = 1; DATA_IN = 16'h0099; CLR = 1;
    cycle();
    DATA_VALID = 0; CLR = 0;
    check("ovf.set_beats_clr", OVERFLOW, 1);
    cycle();
    clr1();
    check("ovf.clr2", OVERFLOW, 0);

    // Full FIFO: simultaneous write and pop both complete.
    DATA_VALID = 1; DATA_IN = 16'h1234; RD_EN = 1;
    cycle();
    DATA_VALID = 0; RD_EN = 0;
    check("full_rw.fill", FILL_LEVEL, 8);
    check("full_rw.ovf", OVERFLOW, 0);
    check("full_rw.head", DATA_OUT, 16'h0022);
    repeat (7) pop1();
    check("full_rw.last", DATA_OUT, 16'h1234);
    check("full_rw.last_fill", FILL_LEVEL, 1);
    pop1();
    check("full_rw.empty", FILL_LEVEL, 0);

    // Timeout fires exactly TC edges after the start edge.
    sf_pulse();
    for (int i = 1; i <= TC - 1; i++) cycle();
    check("tmo.before", TIMEOUT, 0);
    cycle();
    check("tmo.at", TIMEOUT, 1);
    clr1();
    check("tmo.clr", TIMEOUT, 0);

    // Sample on the final count is on time.
    sf_pulse();
    for (int i = 1; i <= TC - 1; i++) cycle();
    DATA_VALID = 1; DATA_IN = 16'hABCD;
    cycle();
    DATA_VALID = 0;
    check("ontime.tmo", TIMEOUT, 0);
    check("ontime.fill", FILL_LEVEL, 1);
    check("ontime.dout", DATA_OUT, 16'hABCD);
    repeat (5) cycle();
    check("ontime.tmo_after", TIMEOUT, 0);
    pop1();

    // A second start strobe restarts the count.
    sf_pulse();
    for (int i = 1; i <= 39; i++) cycle();
    sf_pulse();
    for (int i = 1; i <= TC - 1; i++) cycle();
    check("restart.before", TIMEOUT, 0);
    cycle();
    check("restart.at", TIMEOUT, 1);
    clr1();

    // EN low blocks writes; re-enabling mid-level needs a fresh edge.
    EN = 0; DATA_VALID = 1; DATA_IN = 16'h1111;
    repeat (10) cycle();
    check("en_low.fill", FILL_LEVEL, 0);
    EN = 1;
    repeat (3) cycle();
    check("en_rise.fill", FILL_LEVEL, 0);
    DATA_VALID = 0;
    cycle();
    DATA_VALID = 1; DATA_IN = 16'h2222;
    cycle();
    DATA_VALID = 0;
    check("en_edge.fill", FILL_LEVEL, 1);
    check("en_edge.dout", DATA_OUT, 16'h2222);
    pop1();

    // EN low abandons a pending wait.
    sf_pulse();
    repeat (10) cycle();
    EN = 0;
    cycle();
    EN = 1;
    repeat (70) cycle();
    check("en_idle.tmo", TIMEOUT, 0);

    // Asynchronous reset mid-operation.
    for (int v = 1; v <= 9; v++) pulse(16'(v));
    repeat (3) pop1();
    sf_pulse();
    repeat (5) cycle();
    check("pre_rst.fill", FILL_LEVEL, 5);
    check("pre_rst.ovf", OVERFLOW, 1);
    #2;
    nRST = 0;
    #1;
    check_all_zero("async_rst");
    model_reset();
    @(negedge CLK);
    nRST = 1;
    pulse(16'h0055);
    check("post_rst.fill", FILL_LEVEL, 1);
    check("post_rst.dout", DATA_OUT, 16'h0055);
    repeat (70) cycle();
    check("post_rst.tmo", TIMEOUT, 0);
    pop1();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      EN         = ($urandom_range(0, 19) != 0);
      START_FLAG = ($urandom_range(0, 39) == 0);
      DATA_VALID = ($urandom_range(0, 2) == 0);
      DATA_IN    = 16'($urandom);
      RD_EN      = (i < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      CLR        = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/filter_capture.md
FILTER_CAPTURE -- requirements
Module: filter_capture

Interface
REQ-001 The block SHALL have parameter BITWIDTH, default 16, width of captured filter samples.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, number of buffered samples (power of two, at least 2).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 64, maximum CLK cycles from START_FLAG to DATA_VALID.
REQ-004 The block SHALL have port CLK  input  1  single system clock; all logic on the rising edge.
REQ-005 The block SHALL have port nRST  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port EN  input  1  capture enable.
REQ-007 The block SHALL have port START_FLAG  input  1  sample strobe, the same strobe that drives the filter.
REQ-008 The block SHALL have port DATA_IN  input  BITWIDTH  filter output sample, offset-binary.
REQ-009 The block SHALL have port DATA_VALID  input  1  filter result-ready level; its rising edge marks a new sample.
REQ-010 The block SHALL have port RD_EN  input  1  pop request from the consumer.
REQ-011 The block SHALL have port CLR  input  1  synchronous clear of the sticky flags.
REQ-012 The block SHALL have port DATA_OUT  output  BITWIDTH  FIFO head, first-word fall-through.
REQ-013 The block SHALL have port DATA_OUT_VALID  output  1  FIFO non-empty.
REQ-014 The block SHALL have port FILL_LEVEL  output  clog2(FIFO_DEPTH)+1  number of stored samples.
REQ-015 The block SHALL have port OVERFLOW  output  1  sticky flag: a sample was dropped because the FIFO was full.
REQ-016 The block SHALL have port TIMEOUT  output  1  sticky flag: no DATA_VALID arrived within TIMEOUT_CYC.

Function
REQ-017 The block SHALL register DATA_VALID and START_FLAG once each and detect a rising edge as "current high, previous low".
REQ-018 With EN high, a DATA_VALID rising edge seen at clock edge k SHALL write DATA_IN into the FIFO at edge k; DATA_OUT_VALID and FILL_LEVEL SHALL reflect the write after edge k.
REQ-019 A held-high DATA_VALID SHALL produce exactly one write.
REQ-020 RD_EN with the FIFO non-empty SHALL pop the head at the clock edge; RD_EN on an empty FIFO SHALL be ignored and SHALL NOT underflow the pointers.
REQ-021 DATA_OUT SHALL present mem[rd_ptr] when the FIFO is non-empty and all-zero when it is empty.
REQ-022 A write on a full FIFO without a simultaneous pop SHALL be dropped and SHALL set OVERFLOW.
REQ-023 A write and a pop in the same cycle on a full FIFO SHALL both complete; FILL_LEVEL stays at FIFO_DEPTH and OVERFLOW is not set.
REQ-024 A write and RD_EN in the same cycle on an empty FIFO SHALL store the sample; the pop is ignored and FILL_LEVEL becomes 1.
REQ-025 Read and write pointers SHALL be clog2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full/empty SHALL be decoded from the MSB and the address bits.
REQ-026 The timeout FSM SHALL have two states, IDLE and WAIT:
  - IDLE -> WAIT on a START_FLAG rising edge with EN high; counter cleared to 0.
  - WAIT: counter increments each cycle.
  - WAIT -> IDLE on a DATA_VALID rising edge.
  - WAIT -> IDLE and TIMEOUT set when the counter reaches TIMEOUT_CYC-1.
REQ-027 A START_FLAG rising edge while in WAIT SHALL restart the counter at 0 and remain in WAIT.
REQ-028 A DATA_VALID edge and the counter reaching TIMEOUT_CYC-1 in the same cycle SHALL count as on time: the sample is written and TIMEOUT is not set.
REQ-029 EN low SHALL block writes and force the FSM to IDLE; pops and the flags SHALL remain functional.
REQ-030 CLR SHALL clear OVERFLOW and TIMEOUT at the next edge; a set event in the same cycle SHALL take priority over CLR.

Reset
REQ-031 nRST low SHALL immediately clear the pointers, edge registers, counter and flags and force the FSM to IDLE, including mid-operation.
REQ-032 During reset the outputs SHALL be DATA_OUT=0, DATA_OUT_VALID=0, FILL_LEVEL=0, OVERFLOW=0, TIMEOUT=0.
REQ-033 FIFO memory contents SHALL NOT require reset.

Verification (BITWIDTH=16, FIFO_DEPTH=8, TIMEOUT_CYC=64)
REQ-034 Bench: EN=1, DATA_IN=0x8000, DATA_VALID pulse -> DATA_OUT=0x8000, DATA_OUT_VALID=1, FILL_LEVEL=1 one edge later; RD_EN for one cycle -> FILL_LEVEL=0, DATA_OUT=0.
REQ-035 Bench: 9 DATA_VALID pulses carrying 1..9 with no reads -> FILL_LEVEL=8, OVERFLOW=1; 8 pops return 1..8.
REQ-036 Bench: FIFO full, then write 0x1234 with RD_EN in the same cycle -> FILL_LEVEL=8, OVERFLOW=0, last pop returns 0x1234.
REQ-037 Bench: START_FLAG edge, no DATA_VALID -> TIMEOUT=1 exactly 64 cycles later; DATA_VALID edge at cycle 63 -> TIMEOUT=0 and the sample is stored.
REQ-038 Bench: nRST pulsed low with FILL_LEVEL=5, FSM in WAIT and OVERFLOW=1 -> all outputs 0 asynchronously; the next DATA_VALID pulse gives FILL_LEVEL=1.
REQ-039 Bench: EN=0 with DATA_VALID held high for 10 cycles -> no writes; raising EN while DATA_VALID stays high -> no write until the next rising edge.
